ddr_port_arbiter: RTL and testbench
===================================

// Module: ddr_port_arbiter
// PURPOSE
//  Shares the single DDR3 ddr_if port (clkddr domain) between NUM_REQ bus masters:
//  the FMV frameplayer (line fetch, real-time), the MPEG video decoder (frame writes)
//  and spare requesters. Grants exclusive ownership per acquire window and tracks
//  outstanding read beats so ownership never changes mid-burst. Sits between the
//  requesters and the top-level DDR3 ddr_if.
// PARAMETERS
//  NUM_REQ   3   number of requesters; index 0 is fixed highest priority (frameplayer)
//  CNT_W     10  width of outstanding-read-beat counter (must hold >= 2*255)
// PORTS
//  clkddr          in   1            DDR clock; all logic in this domain
//  reset           in   1            synchronous, active-high
//  req_acquire     in   NUM_REQ      per-requester ownership request
//  req_read        in   NUM_REQ      per-requester read strobe
//  req_write       in   NUM_REQ      per-requester write strobe
//  req_addr        in   NUM_REQ*29   per-requester word address
//  req_burstcnt    in   NUM_REQ*8    per-requester burst length
//  req_wdata       in   NUM_REQ*64   per-requester write data
//  req_byteenable  in   NUM_REQ*8    per-requester byte enables
//  req_busy        out  NUM_REQ      per-requester busy (1 = not owner or ddr_busy)
//  req_rdata_ready out  NUM_REQ      per-requester read beat valid (owner only)
//  req_rdata       out  64           read data, broadcast to all requesters
//  grant           out  NUM_REQ      one-hot current owner; 0 when idle
//  ddr_read/ddr_write      out 1     to DDR3 port
//  ddr_addr out 29; ddr_burstcnt out 8; ddr_wdata out 64; ddr_byteenable out 8
//  ddr_busy        in   1            DDR3 port stall
//  ddr_rdata_ready in   1            DDR3 read beat valid
//  ddr_rdata       in   64           DDR3 read data
// BEHAVIOUR
//  FSM: IDLE -> OWNED -> DRAIN -> IDLE.
//  Reset: state IDLE, grant=0, owner index 0, outstanding=0, rr pointer=1.
//   Outputs during reset: ddr_read=0, ddr_write=0, ddr_byteenable=8'hff,
//   req_busy=all 1, req_rdata_ready=0.
//  IDLE: if any req_acquire is high, latch the winner and enter OWNED on the next edge.
//   grant is registered, so 1 cycle separates acquire from grant.
//   Requester 0 wins whenever its acquire is high.
//   Otherwise round-robin over 1..NUM_REQ-1, starting at the rr pointer.
//   After a grant to k>=1, the rr pointer becomes k+1, wrapping to 1.
//  OWNED: ddr_* signals are a combinational mux of the owner's req_* signals.
//   Non-owners: req_busy=1, req_rdata_ready=0; their read/write are ignored.
//   Owner: req_busy=ddr_busy; req_rdata_ready=ddr_rdata_ready.
//   Read accepted when ddr_read && !ddr_busy: outstanding += ddr_burstcnt.
//   Each ddr_rdata_ready: outstanding -= 1.
//   Accept and beat in the same cycle: outstanding += burstcnt-1.
//   Owner acquire low -> DRAIN.
//   In DRAIN: ddr_read=0, ddr_write=0, owner still receives its rdata_ready beats.
//  DRAIN: when outstanding==0 -> IDLE with grant=0.
//   At least 1 idle cycle always separates two owners.
//   If the owner re-raises acquire while in DRAIN, the request is arbitrated
//   fresh from IDLE. There is no fast re-grant.
//  No preemption: requester 0 waits for the current owner to release.
//   Worst case wait is the current owner's hold time plus the drain time.
//  ddr_rdata_ready with outstanding==0 (should not occur): drop the beat, hold the
//   counter at 0 (no underflow), and raise nothing. ddr_rdata_ready while IDLE is
//   dropped the same way.
//  Reset mid-burst: all state clears within 1 cycle. Beats arriving later are dropped.
//  Write beats are not counted; writes complete when accepted (ddr_write && !ddr_busy).
// TESTING
//  1. R1 acquires, reads burstcnt=8, drops acquire after the read is accepted
//     -> grant=3'b010 one cycle after acquire; 8 beats reach R1 only; grant=0 only
//     after the 8th beat.
//  2. R0 and R2 raise acquire in the same cycle while IDLE -> R0 granted first;
//     R2 granted 1 cycle after R0 finishes draining.
//  3. R1 and R2 request continuously, releasing after each burst
//     -> grants alternate 010,100,010...; no requester is granted twice in a row.
//  4. ddr_busy held high for 5 cycles during an owner read -> read held, owner sees
//     busy=1, outstanding unchanged until acceptance; non-owners see busy=1.
//  5. Reset asserted with outstanding=5 -> next cycle grant=0, outstanding=0;
//     3 trailing ddr_rdata_ready pulses produce no req_rdata_ready.
//  6. Owner write burst of 4 accepted beats, then releases -> DRAIN->IDLE in 1 cycle
//     (outstanding stays 0); ddr_wdata/byteenable match the owner on every beat.

Source files
------------

// File: rtl/ddr_port_arbiter.sv
// Arbitrates exclusive ownership of the single DDR3 port among NUM_REQ bus masters.
// Requester 0 has fixed priority; the rest rotate. Ownership is held until every issued read beat has returned.
module ddr_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 10
) (
  input  logic                   clkddr,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_acquire,
  input  logic [NUM_REQ-1:0]     req_read,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*29-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]   req_burstcnt,
  input  logic [NUM_REQ*64-1:0]  req_wdata,
  input  logic [NUM_REQ*8-1:0]   req_byteenable,
  output logic [NUM_REQ-1:0]     req_busy,
  output logic [NUM_REQ-1:0]     req_rdata_ready,
  output logic [63:0]            req_rdata,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   ddr_read,
  output logic                   ddr_write,
  output logic [28:0]            ddr_addr,
  output logic [7:0]             ddr_burstcnt,
  output logic [63:0]            ddr_wdata,
  output logic [7:0]             ddr_byteenable,
  input  logic                   ddr_busy,
  input  logic                   ddr_rdata_ready,
  input  logic [63:0]            ddr_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RR_N  = (NUM_REQ > 1) ? NUM_REQ - 1 : 1;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    DRAIN
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_next;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   outstanding_next;
  logic               any_acquire;
  logic               owner_acquire;
  logic               read_accept;
  logic               beat_valid;
  logic               found;
  int                 k;

  assign any_acquire   = |req_acquire;
  assign owner_acquire = req_acquire[owner];
  assign read_accept   = ddr_read && !ddr_busy;
  // Beats with nothing outstanding are dropped so the counter can never underflow.
  assign beat_valid    = ddr_rdata_ready && (outstanding != '0) && (state != IDLE);
  assign req_rdata     = ddr_rdata;

  always_comb begin
    outstanding_next = outstanding;
    if (read_accept) begin
      outstanding_next = outstanding_next + CNT_W'(ddr_burstcnt);
    end
    if (beat_valid) begin
      outstanding_next = outstanding_next - CNT_W'(1);
    end
  end

  // Requester 0 always wins; otherwise scan 1..NUM_REQ-1 starting from rr_ptr.
  always_comb begin
    winner  = '0;
    rr_next = rr_ptr;
    found   = 1'b0;
    k       = 0;
    if (!req_acquire[0]) begin
      for (int j = 0; j < NUM_REQ - 1; j++) begin
        k = ((int'(rr_ptr) - 1 + j) % RR_N) + 1;
        if (!found && req_acquire[k]) begin
          found   = 1'b1;
          winner  = IDX_W'(k);
          rr_next = (k == NUM_REQ - 1) ? IDX_W'(1) : IDX_W'(k + 1);
        end
      end
    end
  end

  always_ff @(posedge clkddr) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_acquire)        state_next = OWNED;
      OWNED:   if (!owner_acquire)     state_next = DRAIN;
      DRAIN:   if (outstanding == '0)  state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkddr) begin
    if (reset) begin
      grant       <= '0;
      owner       <= '0;
      outstanding <= '0;
      rr_ptr      <= IDX_W'(1);
    end else begin
      outstanding <= outstanding_next;
      if (state == IDLE && any_acquire) begin
        owner <= winner;
        grant <= NUM_REQ'(1) << winner;
        if (!req_acquire[0]) begin
          rr_ptr <= rr_next;
        end
      end
      if (state == DRAIN && outstanding == '0) begin
        grant <= '0;
      end
    end
  end

  // Only the owner in OWNED drives the port; reset forces the quiet values regardless of state.
  always_comb begin
    ddr_read        = 1'b0;
    ddr_write       = 1'b0;
    ddr_addr        = '0;
    ddr_burstcnt    = '0;
    ddr_wdata       = '0;
    ddr_byteenable  = 8'hff;
    req_busy        = '1;
    req_rdata_ready = '0;
    if (!reset) begin
      if (state == OWNED) begin
        ddr_read       = req_read[owner];
        ddr_write      = req_write[owner];
        ddr_addr       = req_addr[int'(owner)*29 +: 29];
        ddr_burstcnt   = req_burstcnt[int'(owner)*8 +: 8];
        ddr_wdata      = req_wdata[int'(owner)*64 +: 64];
        ddr_byteenable = req_byteenable[int'(owner)*8 +: 8];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          req_busy[i]        = ddr_busy;
          req_rdata_ready[i] = beat_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural ownership model.
module tb_ddr_port_arbiter;

  localparam int N = 3;

  logic            clkddr = 1'b0;
  logic            reset  = 1'b1;
  logic [N-1:0]    req_acquire = '0;
  logic [N-1:0]    req_read = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*29-1:0] req_addr = '0;
  logic [N*8-1:0]  req_burstcnt = '0;
  logic [N*64-1:0] req_wdata = '0;
  logic [N*8-1:0]  req_byteenable = '0;
  logic [N-1:0]    req_busy;
  logic [N-1:0]    req_rdata_ready;
  logic [63:0]     req_rdata;
  logic [N-1:0]    grant;
  logic            ddr_read;
  logic            ddr_write;
  logic [28:0]     ddr_addr;
  logic [7:0]      ddr_burstcnt;
  logic [63:0]     ddr_wdata;
  logic [7:0]      ddr_byteenable;
  logic            ddr_busy = 1'b0;
  logic            ddr_rdata_ready = 1'b0;
  logic [63:0]     ddr_rdata = '0;

  // Model: owner index (-1 when idle), releasing flag, beats still owed, next rotating candidate.
  int m_owner = -1;
  bit m_drain = 1'b0;
  int m_out   = 0;
  int m_rr    = 1;

  int n_vec = 0;
  int n_bad = 0;
  int ops_left[N];

  ddr_port_arbiter #(.NUM_REQ(N), .CNT_W(10)) dut (
    .clkddr(clkddr), .reset(reset),
    .req_acquire(req_acquire), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_burstcnt(req_burstcnt), .req_wdata(req_wdata),
    .req_byteenable(req_byteenable), .req_busy(req_busy),
    .req_rdata_ready(req_rdata_ready), .req_rdata(req_rdata), .grant(grant),
    .ddr_read(ddr_read), .ddr_write(ddr_write), .ddr_addr(ddr_addr),
    .ddr_burstcnt(ddr_burstcnt), .ddr_wdata(ddr_wdata), .ddr_byteenable(ddr_byteenable),
    .ddr_busy(ddr_busy), .ddr_rdata_ready(ddr_rdata_ready), .ddr_rdata(ddr_rdata)
  );

  always #5 clkddr = ~clkddr;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0] e_grant, e_busy, e_rdy;
    logic e_read, e_write;
    e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_read  = 1'b0;
    e_write = 1'b0;
    for (int i = 0; i < N; i++) begin
      e_busy[i] = reset || (i != m_owner) || ddr_busy;
      e_rdy[i]  = !reset && (i == m_owner) && ddr_rdata_ready && (m_out > 0);
    end
    if (!reset && m_owner >= 0 && !m_drain) begin
      e_read  = req_read[m_owner];
      e_write = req_write[m_owner];
      cmp("ddr_addr", ddr_addr, req_addr[m_owner*29 +: 29]);
      cmp("ddr_burstcnt", ddr_burstcnt, req_burstcnt[m_owner*8 +: 8]);
      cmp("ddr_wdata", ddr_wdata, req_wdata[m_owner*64 +: 64]);
      cmp("ddr_byteenable", ddr_byteenable, req_byteenable[m_owner*8 +: 8]);
    end
    if (reset) begin
      cmp("reset byteenable", ddr_byteenable, 8'hff);
    end
    cmp("grant", grant, e_grant);
    cmp("ddr_read", ddr_read, e_read);
    cmp("ddr_write", ddr_write, e_write);
    cmp("req_busy", req_busy, e_busy);
    cmp("req_rdata_ready", req_rdata_ready, e_rdy);
    cmp("req_rdata", req_rdata, ddr_rdata);
  endtask

  task automatic updateModel();
    bit accepted, beat, leave;
    if (reset) begin
      m_owner = -1;
      m_drain = 1'b0;
      m_out   = 0;
      m_rr    = 1;
    end else if (m_owner < 0) begin
      if (|req_acquire) begin
        if (req_acquire[0]) begin
          m_owner = 0;
        end else begin
          for (int s = 0; s < N - 1; s++) begin
            int cand;
            cand = m_rr + s;
            if (cand > N - 1) cand -= (N - 1);
            if (req_acquire[cand]) begin
              m_owner = cand;
              break;
            end
          end
          m_rr = (m_owner == N - 1) ? 1 : m_owner + 1;
        end
        m_drain = 1'b0;
      end
    end else begin
      accepted = !m_drain && req_read[m_owner] && !ddr_busy;
      beat     = ddr_rdata_ready && (m_out > 0);
      leave    = m_drain && (m_out == 0);
      if (!m_drain && !req_acquire[m_owner]) m_drain = 1'b1;
      if (accepted) m_out += int'(req_burstcnt[m_owner*8 +: 8]);
      if (beat) m_out -= 1;
      if (leave) begin
        m_owner = -1;
        m_drain = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus();
    @(negedge clkddr);
    checkOutput();
    @(posedge clkddr);
    updateModel();
    #1;
  endtask

  task automatic waitGrant(input string name, input logic [N-1:0] exp, input int budget);
    for (int c = 0; c < budget; c++) begin
      applyStimulus();
      if (grant != '0) break;
    end
    cmp(name, grant, exp);
  endtask

  task automatic driveRandom();
    reset = ($urandom_range(0, 499) == 0);
    for (int i = 0; i < N; i++) begin
      if (!req_acquire[i]) begin
        if ($urandom_range(0, 99) < ((i == 0) ? 4 : 12)) begin
          req_acquire[i] = 1'b1;
          ops_left[i] = $urandom_range(1, 12);
        end
      end else if (m_owner == i && !m_drain) begin
        if (ops_left[i] == 0) req_acquire[i] = 1'b0;
        else ops_left[i]--;
      end
      req_read[i]              = ($urandom_range(0, 2) == 0);
      req_write[i]             = !req_read[i] && ($urandom_range(0, 3) == 0);
      req_addr[i*29 +: 29]     = 29'($urandom);
      req_burstcnt[i*8 +: 8]   = 8'($urandom_range(1, 16));
      req_wdata[i*64 +: 64]    = {$urandom, $urandom};
      req_byteenable[i*8 +: 8] = 8'($urandom);
    end
    ddr_busy        = ($urandom_range(0, 3) == 0);
    ddr_rdata_ready = (m_out > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
    ddr_rdata       = {$urandom, $urandom};
  endtask

  initial begin
    logic [N-1:0] rr_seq [4];
    logic [63:0]  wd;
    logic [7:0]   be;
    int           o;

    @(posedge clkddr);
    #1;
    applyStimulus();
    applyStimulus();
    cmp("reset grant", grant, 3'b000);
    cmp("reset busy", req_busy, 3'b111);
    cmp("reset byteenable literal", ddr_byteenable, 8'hff);
    reset = 1'b0;

    // Single owner read burst of 8, released after acceptance.
    req_acquire[1] = 1'b1;
    applyStimulus();
    cmp("t1 grant", grant, 3'b010);
    req_read[1] = 1'b1;
    req_burstcnt[8 +: 8] = 8'd8;
    applyStimulus();
    req_read[1] = 1'b0;
    req_acquire[1] = 1'b0;
    ddr_rdata_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ddr_rdata = {$urandom, $urandom};
      applyStimulus();
      if (b == 0) cmp("t1 beat to R1", req_rdata_ready, 3'b010);
    end
    cmp("t1 grant after 8th beat", grant, 3'b010);
    ddr_rdata_ready = 1'b0;
    applyStimulus();
    cmp("t1 grant released", grant, 3'b000);

    // Priority: R0 beats R2, R2 follows after the idle gap.
    req_acquire = 3'b101;
    applyStimulus();
    cmp("t2 R0 first", grant, 3'b001);
    req_acquire[0] = 1'b0;
    applyStimulus();
    cmp("t2 R0 draining", grant, 3'b001);
    applyStimulus();
    cmp("t2 idle gap", grant, 3'b000);
    applyStimulus();
    cmp("t2 R2 next", grant, 3'b100);
    req_acquire[2] = 1'b0;
    applyStimulus();
    applyStimulus();

    // Round-robin between R1 and R2.
    rr_seq[0] = 3'b010; rr_seq[1] = 3'b100; rr_seq[2] = 3'b010; rr_seq[3] = 3'b100;
    req_acquire = 3'b110;
    for (int it = 0; it < 4; it++) begin
      waitGrant("t3 rr grant", rr_seq[it], 4);
      applyStimulus();
      o = (it % 2 == 0) ? 1 : 2;
      req_acquire[o] = 1'b0;
      applyStimulus();
      req_acquire[o] = 1'b1;
      applyStimulus();
    end
    req_acquire = '0;
    applyStimulus();
    applyStimulus();

    // Stalled read.
    req_acquire[1] = 1'b1;
    applyStimulus();
    ddr_busy = 1'b1;
    req_read[1] = 1'b1;
    req_burstcnt[8 +: 8] = 8'd4;
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      if (c == 0) begin
        cmp("t4 busy all", req_busy, 3'b111);
        cmp("t4 read held", ddr_read, 1'b1);
      end
    end
    ddr_busy = 1'b0;
    applyStimulus();
    cmp("t4 owner not busy", req_busy, 3'b101);
    req_read[1] = 1'b0;
    req_acquire[1] = 1'b0;
    ddr_rdata_ready = 1'b1;
    for (int b = 0; b < 4; b++) applyStimulus();
    ddr_rdata_ready = 1'b0;
    applyStimulus();
    cmp("t4 released", grant, 3'b000);

    // Reset with beats still owed.
    req_acquire[1] = 1'b1;
    applyStimulus();
    req_read[1] = 1'b1;
    req_burstcnt[8 +: 8] = 8'd5;
    applyStimulus();
    req_read[1] = 1'b0;
    reset = 1'b1;
    applyStimulus();
    cmp("t5 grant after reset", grant, 3'b000);
    reset = 1'b0;
    req_acquire[1] = 1'b0;
    ddr_rdata_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      applyStimulus();
      cmp("t5 trailing beat dropped", req_rdata_ready, 3'b000);
    end
    ddr_rdata_ready = 1'b0;

    // Write burst, no beats owed on release.
    req_acquire[2] = 1'b1;
    applyStimulus();
    req_write[2] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wd = 64'hA5A5_0000_0000_0000 + 64'(b);
      be = 8'h0F ^ 8'(b);
      req_wdata[128 +: 64] = wd;
      req_byteenable[16 +: 8] = be;
      #1;
      cmp("t6 wdata", ddr_wdata, wd);
      cmp("t6 byteenable", ddr_byteenable, be);
      applyStimulus();
    end
    req_write[2] = 1'b0;
    req_acquire[2] = 1'b0;
    applyStimulus();
    cmp("t6 drain", grant, 3'b100);
    applyStimulus();
    cmp("t6 idle", grant, 3'b000);

    for (int i = 0; i < N; i++) ops_left[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      driveRandom();
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
